// File: rtl/vram_arbiter.sv
// ---------------------------------------------------------------------------------------------
// vram_arbiter
//   Shares the single VRAM SRAM port between display scanout, the draw engine and the CPU/DMA
//   transfer unit. At most one access is granted per cycle. The SRAM strobes/address/data are
//   registered, and read data is steered back to its requester through a tag pipe that tracks
//   the SRAM read latency.
//
//   Arbitration: display has strict priority (StDispPri) but, after DISP_BURST consecutive
//   display grants with draw/xfer waiting, one cycle (StShare) is handed to draw/xfer.
//   Draw and xfer arbitrate round-robin between themselves.
//
// Ports
//   clk, rst                  clock, asynchronous active-low reset
//   disp_req/addr             display read request      -> disp_gnt, disp_rvalid
//   draw_req/we/addr/wdata    draw engine request       -> draw_gnt, draw_rvalid
//   xfer_req/we/addr/wdata    CPU/DMA transfer request  -> xfer_gnt, xfer_rvalid
//   rdata                     registered read data, qualified by *_rvalid
//   mem_addr/re/we/wdata      registered SRAM port outputs
//   mem_rdata                 SRAM read data
//
// Optional build macro VRAM_ARB_STATS_EN adds:
//   stat_clr                  synchronous clear of all statistics counters (wins over counting)
//   stat_disp/draw/xfer       32-bit grant counters
//   stat_share                32-bit count of entries into StShare
// ---------------------------------------------------------------------------------------------
module vram_arbiter #(
  parameter int unsigned ADDR_W     = 19,
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned RD_LAT     = 2,
  parameter int unsigned DISP_BURST = 8
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic              disp_gnt,
  output logic              disp_rvalid,

  input  logic              draw_req,
  input  logic              draw_we,
  input  logic [ADDR_W-1:0] draw_addr,
  input  logic [DATA_W-1:0] draw_wdata,
  output logic              draw_gnt,
  output logic              draw_rvalid,

  input  logic              xfer_req,
  input  logic              xfer_we,
  input  logic [ADDR_W-1:0] xfer_addr,
  input  logic [DATA_W-1:0] xfer_wdata,
  output logic              xfer_gnt,
  output logic              xfer_rvalid,

  output logic [DATA_W-1:0] rdata,

  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_re,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
`ifdef VRAM_ARB_STATS_EN
  input  logic              stat_clr,
  output logic [31:0]       stat_disp,
  output logic [31:0]       stat_draw,
  output logic [31:0]       stat_xfer,
  output logic [31:0]       stat_share,
`endif
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int unsigned CntW = $clog2(DISP_BURST + 1);
  localparam logic [CntW-1:0] BurstMax = CntW'(DISP_BURST);

  localparam logic [1:0] IdDisp = 2'd0;
  localparam logic [1:0] IdDraw = 2'd1;
  localparam logic [1:0] IdXfer = 2'd2;

  typedef enum logic [0:0] {StDispPri, StShare} state_e;

  typedef struct packed {
    logic       valid;
    logic [1:0] id;
  } tag_t;

  state_e              state_q, state_d;
  logic [CntW-1:0]     burst_cnt_q, burst_cnt_d;
  logic                rr_xfer_q, rr_xfer_d;   // 1: xfer preferred, 0: draw preferred

  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                mem_re_q, mem_re_d;
  logic                mem_we_q, mem_we_d;

  tag_t [RD_LAT:0]     tag_q, tag_d;
  tag_t                tag_new;
  tag_t                tag_ret;

  logic                disp_rvalid_q, disp_rvalid_d;
  logic                draw_rvalid_q, draw_rvalid_d;
  logic                xfer_rvalid_q, xfer_rvalid_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;

  logic                pick_draw, pick_xfer;
  logic                others_pending;

  // Round-robin pick between draw and xfer; a lone requester wins regardless of the pointer.
  assign pick_draw      = draw_req & (~xfer_req | ~rr_xfer_q);
  assign pick_xfer      = xfer_req & (~draw_req |  rr_xfer_q);
  assign others_pending = draw_req | xfer_req;

  // ---------------------------------------------------------------------------
  // FSM: output process (grants)
  // ---------------------------------------------------------------------------
  always_comb begin
    disp_gnt = 1'b0;
    draw_gnt = 1'b0;
    xfer_gnt = 1'b0;
    unique case (state_q)
      StDispPri: begin
        if (disp_req) begin
          disp_gnt = 1'b1;
        end else begin
          draw_gnt = pick_draw;
          xfer_gnt = pick_xfer;
        end
      end
      StShare: begin
        // Display is locked out for this one cycle even if requesting.
        draw_gnt = pick_draw;
        xfer_gnt = pick_xfer;
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state process (state, burst counter, round-robin pointer)
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    burst_cnt_d = burst_cnt_q;
    rr_xfer_d   = rr_xfer_q;

    if (draw_gnt) begin
      rr_xfer_d = 1'b1;
    end else if (xfer_gnt) begin
      rr_xfer_d = 1'b0;
    end

    unique case (state_q)
      StDispPri: begin
        if (disp_gnt && others_pending) begin
          // Saturating count of display grants made while someone else waits.
          burst_cnt_d = (burst_cnt_q == BurstMax) ? burst_cnt_q : burst_cnt_q + CntW'(1);
          if (burst_cnt_d == BurstMax) begin
            state_d = StShare;
          end
        end else begin
          burst_cnt_d = '0;
        end
      end
      StShare: begin
        state_d     = StDispPri;
        burst_cnt_d = '0;
      end
      default: begin
        state_d     = StDispPri;
        burst_cnt_d = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // SRAM port next values and read tag for the granted access
  // ---------------------------------------------------------------------------
  always_comb begin
    mem_re_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    tag_new     = '0;
    if (disp_gnt) begin
      mem_re_d      = 1'b1;
      mem_addr_d    = disp_addr;
      tag_new.valid = 1'b1;
      tag_new.id    = IdDisp;
    end else if (draw_gnt) begin
      mem_re_d      = ~draw_we;
      mem_we_d      = draw_we;
      mem_addr_d    = draw_addr;
      mem_wdata_d   = draw_wdata;
      tag_new.valid = ~draw_we;
      tag_new.id    = IdDraw;
    end else if (xfer_gnt) begin
      mem_re_d      = ~xfer_we;
      mem_we_d      = xfer_we;
      mem_addr_d    = xfer_addr;
      mem_wdata_d   = xfer_wdata;
      tag_new.valid = ~xfer_we;
      tag_new.id    = IdXfer;
    end
  end

  // ---------------------------------------------------------------------------
  // Tag pipe and read return steering
  // ---------------------------------------------------------------------------
  // Stage RD_LAT lines up with the cycle in which mem_rdata is valid; the return registers
  // then add the final cycle, giving RD_LAT+1 cycles from grant edge to *_rvalid.
  assign tag_ret = tag_q[RD_LAT];

  always_comb begin
    tag_d[0] = tag_new;
    for (int unsigned i = 1; i <= RD_LAT; i++) begin
      tag_d[i] = tag_q[i-1];
    end
    disp_rvalid_d = tag_ret.valid && (tag_ret.id == IdDisp);
    draw_rvalid_d = tag_ret.valid && (tag_ret.id == IdDraw);
    xfer_rvalid_d = tag_ret.valid && (tag_ret.id == IdXfer);
    rdata_d       = tag_ret.valid ? mem_rdata : rdata_q;
  end

  // ---------------------------------------------------------------------------
  // FSM: state register and all other flops
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= StDispPri;
      burst_cnt_q   <= '0;
      rr_xfer_q     <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      mem_re_q      <= 1'b0;
      mem_we_q      <= 1'b0;
      tag_q         <= '0;
      disp_rvalid_q <= 1'b0;
      draw_rvalid_q <= 1'b0;
      xfer_rvalid_q <= 1'b0;
      rdata_q       <= '0;
    end else begin
      state_q       <= state_d;
      burst_cnt_q   <= burst_cnt_d;
      rr_xfer_q     <= rr_xfer_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      mem_re_q      <= mem_re_d;
      mem_we_q      <= mem_we_d;
      tag_q         <= tag_d;
      disp_rvalid_q <= disp_rvalid_d;
      draw_rvalid_q <= draw_rvalid_d;
      xfer_rvalid_q <= xfer_rvalid_d;
      rdata_q       <= rdata_d;
    end
  end

  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign mem_re      = mem_re_q;
  assign mem_we      = mem_we_q;
  assign disp_rvalid = disp_rvalid_q;
  assign draw_rvalid = draw_rvalid_q;
  assign xfer_rvalid = xfer_rvalid_q;
  assign rdata       = rdata_q;

`ifdef VRAM_ARB_STATS_EN
  // ---------------------------------------------------------------------------
  // Statistics counters (free-running, wrap at 2^32)
  // ---------------------------------------------------------------------------
  logic [31:0] stat_disp_q, stat_disp_d;
  logic [31:0] stat_draw_q, stat_draw_d;
  logic [31:0] stat_xfer_q, stat_xfer_d;
  logic [31:0] stat_share_q, stat_share_d;
  logic        share_entry;

  assign share_entry = (state_q == StDispPri) && (state_d == StShare);

  always_comb begin
    stat_disp_d  = stat_disp_q;
    stat_draw_d  = stat_draw_q;
    stat_xfer_d  = stat_xfer_q;
    stat_share_d = stat_share_q;
    if (stat_clr) begin
      stat_disp_d  = '0;
      stat_draw_d  = '0;
      stat_xfer_d  = '0;
      stat_share_d = '0;
    end else begin
      if (disp_gnt)    stat_disp_d  = stat_disp_q + 32'd1;
      if (draw_gnt)    stat_draw_d  = stat_draw_q + 32'd1;
      if (xfer_gnt)    stat_xfer_d  = stat_xfer_q + 32'd1;
      if (share_entry) stat_share_d = stat_share_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_disp_q  <= '0;
      stat_draw_q  <= '0;
      stat_xfer_q  <= '0;
      stat_share_q <= '0;
    end else begin
      stat_disp_q  <= stat_disp_d;
      stat_draw_q  <= stat_draw_d;
      stat_xfer_q  <= stat_xfer_d;
      stat_share_q <= stat_share_d;
    end
  end

  assign stat_disp  = stat_disp_q;
  assign stat_draw  = stat_draw_q;
  assign stat_xfer  = stat_xfer_q;
  assign stat_share = stat_share_q;
`endif

endmodule

// File: tb/tb_vram_arbiter.sv
// ---------------------------------------------------------------------------------------------
// tb_vram_arbiter
//   Directed testbench for vram_arbiter with hand-computed expectations. Inputs are driven on
//   the falling edge; outputs are sampled on the falling edge (plus #1 for combinational gnt).
// ---------------------------------------------------------------------------------------------
module tb_vram_arbiter;

  localparam int unsigned ADDR_W     = 19;
  localparam int unsigned DATA_W     = 16;
  localparam int unsigned RD_LAT     = 2;
  localparam int unsigned DISP_BURST = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              disp_req;
  logic [ADDR_W-1:0] disp_addr;
  logic              disp_gnt, disp_rvalid;
  logic              draw_req, draw_we;
  logic [ADDR_W-1:0] draw_addr;
  logic [DATA_W-1:0] draw_wdata;
  logic              draw_gnt, draw_rvalid;
  logic              xfer_req, xfer_we;
  logic [ADDR_W-1:0] xfer_addr;
  logic [DATA_W-1:0] xfer_wdata;
  logic              xfer_gnt, xfer_rvalid;
  logic [DATA_W-1:0] rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_re, mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
`ifdef VRAM_ARB_STATS_EN
  logic              stat_clr;
  logic [31:0]       stat_disp, stat_draw, stat_xfer, stat_share;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  vram_arbiter #(
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W),
    .RD_LAT     (RD_LAT),
    .DISP_BURST (DISP_BURST)
  ) u_dut (
    .clk         (clk),
    .rst         (rst),
    .disp_req    (disp_req),
    .disp_addr   (disp_addr),
    .disp_gnt    (disp_gnt),
    .disp_rvalid (disp_rvalid),
    .draw_req    (draw_req),
    .draw_we     (draw_we),
    .draw_addr   (draw_addr),
    .draw_wdata  (draw_wdata),
    .draw_gnt    (draw_gnt),
    .draw_rvalid (draw_rvalid),
    .xfer_req    (xfer_req),
    .xfer_we     (xfer_we),
    .xfer_addr   (xfer_addr),
    .xfer_wdata  (xfer_wdata),
    .xfer_gnt    (xfer_gnt),
    .xfer_rvalid (xfer_rvalid),
    .rdata       (rdata),
    .mem_addr    (mem_addr),
    .mem_re      (mem_re),
    .mem_we      (mem_we),
    .mem_wdata   (mem_wdata),
`ifdef VRAM_ARB_STATS_EN
    .stat_clr    (stat_clr),
    .stat_disp   (stat_disp),
    .stat_draw   (stat_draw),
    .stat_xfer   (stat_xfer),
    .stat_share  (stat_share),
`endif
    .mem_rdata   (mem_rdata)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Single display read; returned data must appear exactly RD_LAT+1 cycles after the grant edge.
  task automatic disp_read_check(input string pfx, input logic [ADDR_W-1:0] addr,
                                 input logic [DATA_W-1:0] data);
    @(negedge clk);
    disp_req  = 1'b1;
    disp_addr = addr;
    #1;
    check_eq({pfx, "_gnt"}, 32'({disp_gnt, draw_gnt, xfer_gnt}), 32'b100);
    @(negedge clk);
    disp_req = 1'b0;
    check_eq({pfx, "_mem_re"}, 32'({mem_re, mem_we}), 32'b10);
    check_eq({pfx, "_mem_addr"}, 32'(mem_addr), 32'(addr));
    @(negedge clk);
    check_eq({pfx, "_rv_early2"}, 32'(disp_rvalid), 32'd0);
    @(negedge clk);
    mem_rdata = data;
    check_eq({pfx, "_rv_early1"}, 32'(disp_rvalid), 32'd0);
    @(negedge clk);
    mem_rdata = '0;
    check_eq({pfx, "_rvalid"}, 32'({disp_rvalid, draw_rvalid, xfer_rvalid}), 32'b100);
    check_eq({pfx, "_rdata"}, 32'(rdata), 32'(data));
    @(negedge clk);
    check_eq({pfx, "_rv_once"}, 32'(disp_rvalid), 32'd0);
  endtask

  initial begin
    logic       act;
    logic       draw_rv_seen;
    logic [2:0] exp_g;

    disp_req = 1'b0; disp_addr = '0;
    draw_req = 1'b0; draw_we = 1'b0; draw_addr = '0; draw_wdata = '0;
    xfer_req = 1'b0; xfer_we = 1'b0; xfer_addr = '0; xfer_wdata = '0;
    mem_rdata = '0;
`ifdef VRAM_ARB_STATS_EN
    stat_clr = 1'b0;
`endif

    // Reset values
    repeat (2) @(negedge clk);
    check_eq("rst_strobes", 32'({mem_re, mem_we, disp_rvalid, draw_rvalid, xfer_rvalid}), 32'd0);
    check_eq("rst_mem_addr", 32'(mem_addr), 32'd0);
    rst = 1'b1;

    // Idle 20 cycles
    act = 1'b0;
    repeat (20) begin
      @(negedge clk);
      #1;
      act = act | disp_gnt | draw_gnt | xfer_gnt | disp_rvalid | draw_rvalid | xfer_rvalid
                | mem_re | mem_we;
    end
    check_eq("idle_activity", 32'(act), 32'd0);
    check_eq("idle_mem_addr", 32'(mem_addr), 32'd0);
    check_eq("idle_mem_wdata", 32'(mem_wdata), 32'd0);
    check_eq("idle_rdata", 32'(rdata), 32'd0);

    // Single display read
    disp_read_check("disp_rd", 19'h00100, 16'hBEEF);

    // Draw write and xfer read held together, pointer at draw
    @(negedge clk);
    draw_req = 1'b1; draw_we = 1'b1; draw_addr = 19'h12345; draw_wdata = 16'h7FFF;
    xfer_req = 1'b1; xfer_we = 1'b0; xfer_addr = 19'h0ABCD; xfer_wdata = 16'h0000;
    #1;
    check_eq("dx_first_gnt", 32'({disp_gnt, draw_gnt, xfer_gnt}), 32'b010);
    draw_rv_seen = 1'b0;
    @(negedge clk);
    draw_rv_seen = draw_rv_seen | draw_rvalid;
    check_eq("dx_wr_strobes", 32'({mem_re, mem_we}), 32'b01);
    check_eq("dx_wr_addr", 32'(mem_addr), 32'h12345);
    check_eq("dx_wr_data", 32'(mem_wdata), 32'h7FFF);
    draw_req = 1'b0;
    #1;
    check_eq("dx_second_gnt", 32'({disp_gnt, draw_gnt, xfer_gnt}), 32'b001);
    @(negedge clk);
    draw_rv_seen = draw_rv_seen | draw_rvalid;
    xfer_req = 1'b0;
    check_eq("dx_rd_strobes", 32'({mem_re, mem_we}), 32'b10);
    check_eq("dx_rd_addr", 32'(mem_addr), 32'h0ABCD);
    @(negedge clk);
    draw_rv_seen = draw_rv_seen | draw_rvalid;
    check_eq("dx_xrv_early2", 32'(xfer_rvalid), 32'd0);
    @(negedge clk);
    draw_rv_seen = draw_rv_seen | draw_rvalid;
    mem_rdata = 16'h1234;
    check_eq("dx_xrv_early1", 32'(xfer_rvalid), 32'd0);
    @(negedge clk);
    draw_rv_seen = draw_rv_seen | draw_rvalid;
    mem_rdata = '0;
    check_eq("dx_xfer_rvalid", 32'({disp_rvalid, draw_rvalid, xfer_rvalid}), 32'b001);
    check_eq("dx_xfer_rdata", 32'(rdata), 32'h1234);
    @(negedge clk);
    draw_rv_seen = draw_rv_seen | draw_rvalid;
    check_eq("dx_xrv_once", 32'(xfer_rvalid), 32'd0);
    check_eq("dx_draw_rv_never", 32'(draw_rv_seen), 32'd0);

    // Display and draw held: 8 display grants then 1 draw grant, repeating
    @(negedge clk);
    disp_req = 1'b1; disp_addr = 19'h00200;
    draw_req = 1'b1; draw_we = 1'b0; draw_addr = 19'h00300;
    for (int c = 0; c < 24; c++) begin
      #1;
      exp_g = ((c % 9) == 8) ? 3'b010 : 3'b100;
      check_eq($sformatf("burst_c%0d", c), 32'({disp_gnt, draw_gnt, xfer_gnt}), 32'(exp_g));
      @(negedge clk);
    end
    disp_req = 1'b0; draw_req = 1'b0;
    #1;
    check_eq("burst_release_idle", 32'({disp_gnt, draw_gnt, xfer_gnt}), 32'b000);

    // Pointer now at xfer: simultaneous draw/xfer grants xfer
    @(negedge clk);
    draw_req = 1'b1; draw_we = 1'b1;
    xfer_req = 1'b1; xfer_we = 1'b1;
    #1;
    check_eq("rr_ptr_xfer", 32'({disp_gnt, draw_gnt, xfer_gnt}), 32'b001);
    // Pointer now at draw, but only xfer requests: xfer still wins
    @(negedge clk);
    draw_req = 1'b0;
    #1;
    check_eq("rr_lone_xfer", 32'({disp_gnt, draw_gnt, xfer_gnt}), 32'b001);
    // Lone draw grant moves the pointer to xfer ahead of the reset test
    @(negedge clk);
    xfer_req = 1'b0; draw_req = 1'b1;
    #1;
    check_eq("rr_lone_draw", 32'({disp_gnt, draw_gnt, xfer_gnt}), 32'b010);
    @(negedge clk);
    draw_req = 1'b0;
    repeat (5) @(negedge clk);

    // Three back-to-back display reads, reset before any returns
    disp_req = 1'b1; disp_addr = 19'h00400;
    repeat (3) @(negedge clk);
    disp_req = 1'b0;
    rst = 1'b0;
    #1;
    check_eq("midrst_strobes", 32'({mem_re, mem_we, disp_rvalid}), 32'd0);
    check_eq("midrst_mem_addr", 32'(mem_addr), 32'd0);
    mem_rdata = 16'h5A5A;
    @(negedge clk);
    rst = 1'b1;
    act = 1'b0;
    repeat (6) begin
      @(negedge clk);
      #1;
      act = act | disp_rvalid | draw_rvalid | xfer_rvalid;
    end
    check_eq("midrst_no_rvalid", 32'(act), 32'd0);
    check_eq("midrst_rdata", 32'(rdata), 32'd0);
    mem_rdata = '0;

    // After reset the pointer is back at draw and reads behave normally
    @(negedge clk);
    draw_req = 1'b1; draw_we = 1'b1;
    xfer_req = 1'b1; xfer_we = 1'b1;
    #1;
    check_eq("postrst_rr_draw", 32'({disp_gnt, draw_gnt, xfer_gnt}), 32'b010);
    @(negedge clk);
    draw_req = 1'b0; xfer_req = 1'b0;
    disp_read_check("postrst_rd", 19'h7FFFF, 16'hC0DE);

`ifdef VRAM_ARB_STATS_EN
    @(negedge clk);
    stat_clr = 1'b1;
    @(negedge clk);
    stat_clr = 1'b0;
    draw_req = 1'b1; draw_we = 1'b1;
    repeat (5) @(negedge clk);
    draw_req = 1'b0;
    xfer_req = 1'b1; xfer_we = 1'b1;
    repeat (3) @(negedge clk);
    xfer_req = 1'b0;
    @(negedge clk);
    check_eq("stat_draw", stat_draw, 32'd5);
    check_eq("stat_xfer", stat_xfer, 32'd3);
    check_eq("stat_disp", stat_disp, 32'd0);
    stat_clr = 1'b1;
    draw_req = 1'b1;
    @(negedge clk);
    stat_clr = 1'b0;
    draw_req = 1'b0;
    #1;
    check_eq("stat_clr_all", stat_disp | stat_draw | stat_xfer | stat_share, 32'd0);
`endif

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
